// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage hazard scoreboard with stall, issue strobe and HLT drain FSM
//
// Purpose: per-register countdown of cycles until each in-flight result is
// forwardable; derives the ID stall and issue strobe, freezes on data-memory
// busy, and drains the pipeline into a halted state on HLT.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   iss_valid           instruction in ID requests issue
//   iss_rs/_rs_used     source Rs and whether it is read
//   iss_rt/_rt_used     source Rt and whether it is read
//   iss_store           instruction is a store (Rt may use MEM->MEM forwarding)
//   iss_wr/iss_rd       instruction writes destination iss_rd
//   iss_lat             cycles until the result is forwardable (0 treated as 1)
//   hlt_req             instruction in ID is HLT
//   flush               squash the instruction in ID
//   mem_busy            data memory not ready, whole pipeline frozen
//   stall               hold PC and IF/ID, bubble into ID/EX
//   iss_fire            instruction accepted into EX this cycle
//   busy_map            bit r set while register r is pending
//   hlt                 processor halted
//   stall_cnt           saturating count of RUN-state stall cycles
module hazard_scoreboard #(
  parameter int NREG      = 16,
  parameter int RIDX_W    = 4,
  parameter int LAT_W     = 3,
  parameter int STORE_FWD = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [RIDX_W-1:0] iss_rs,
  input  logic              iss_rs_used,
  input  logic [RIDX_W-1:0] iss_rt,
  input  logic              iss_rt_used,
  input  logic              iss_store,
  input  logic              iss_wr,
  input  logic [RIDX_W-1:0] iss_rd,
  input  logic [LAT_W-1:0]  iss_lat,
  input  logic              hlt_req,
  input  logic              flush,
  input  logic              mem_busy,
  output logic              stall,
  output logic              iss_fire,
  output logic [NREG-1:0]   busy_map,
  output logic              hlt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_e;

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q [NREG];
  logic [LAT_W-1:0]  cnt_d [NREG];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [LAT_W-1:0]  rs_cnt, rt_cnt, rt_lim, new_lat;
  logic              haz_rs, haz_rt, data_haz, all_idle;

  // Register 0 is never looked up, so a read of r0 always sees "ready".
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    for (int r = 1; r < NREG; r++) begin
      if (iss_rs == RIDX_W'(r)) rs_cnt = cnt_q[r];
      if (iss_rt == RIDX_W'(r)) rt_cnt = cnt_q[r];
    end
  end

  // A store's Rt is consumed one stage later (MEM), so it tolerates one more cycle.
  assign rt_lim   = ((STORE_FWD != 0) && iss_store) ? LAT_W'(2) : LAT_W'(1);
  assign haz_rs   = iss_rs_used && (rs_cnt > LAT_W'(1));
  assign haz_rt   = iss_rt_used && (rt_cnt > rt_lim);
  assign data_haz = iss_valid && (haz_rs || haz_rt) && !flush;

  // Outputs are forced low while reset is held, regardless of inputs.
  assign stall    = rst_n && ((state_q != ST_RUN) || mem_busy || data_haz);
  assign iss_fire = rst_n && (state_q == ST_RUN) && iss_valid && !stall && !flush;
  assign new_lat  = (iss_lat == '0) ? LAT_W'(1) : iss_lat;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_map[r] = (cnt_q[r] != '0);
    end
  end
  assign all_idle  = (busy_map == '0);
  assign hlt       = (state_q == ST_HALTED);
  assign stall_cnt = stall_cnt_q;

  // Scoreboard next state: decrement unless frozen; a new writer overrides (WAW).
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!mem_busy && (cnt_q[r] != '0)) cnt_d[r] = cnt_q[r] - LAT_W'(1);
      if (r != 0 && iss_fire && iss_wr && !hlt_req && (iss_rd == RIDX_W'(r))) cnt_d[r] = new_lat;
      if (r == 0) cnt_d[r] = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_RUN) && stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (iss_fire && hlt_req) state_d = ST_DRAIN;
      ST_DRAIN:  if (all_idle && !mem_busy) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard (STORE_FWD=1 and STORE_FWD=0)
module tb_hazard_scoreboard;

  logic        clk, rst_n;
  logic        iss_valid, iss_rs_used, iss_rt_used, iss_store, iss_wr, hlt_req, flush, mem_busy;
  logic [3:0]  iss_rs, iss_rt, iss_rd;
  logic [2:0]  iss_lat;
  logic        stall_a, fire_a, hlt_a, stall_b, fire_b, hlt_b;
  logic [15:0] busy_a, busy_b, scnt_a, scnt_b;

  int checks = 0;
  int errors = 0;

  hazard_scoreboard #(.STORE_FWD(1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rs_used(iss_rs_used),
    .iss_rt(iss_rt), .iss_rt_used(iss_rt_used), .iss_store(iss_store), .iss_wr(iss_wr),
    .iss_rd(iss_rd), .iss_lat(iss_lat), .hlt_req(hlt_req), .flush(flush), .mem_busy(mem_busy),
    .stall(stall_a), .iss_fire(fire_a), .busy_map(busy_a), .hlt(hlt_a), .stall_cnt(scnt_a));

  hazard_scoreboard #(.STORE_FWD(0)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rs_used(iss_rs_used),
    .iss_rt(iss_rt), .iss_rt_used(iss_rt_used), .iss_store(iss_store), .iss_wr(iss_wr),
    .iss_rd(iss_rd), .iss_lat(iss_lat), .hlt_req(hlt_req), .flush(flush), .mem_busy(mem_busy),
    .stall(stall_b), .iss_fire(fire_b), .busy_map(busy_b), .hlt(hlt_b), .stall_cnt(scnt_b));

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: a result written with latency L at "active time" t becomes
  // forwardable at t+L; active time only advances on cycles without mem_busy.
  int tact [2];
  int ready [2][16];
  int mst [2];      // 0 run, 1 drain, 2 halted
  int msc [2];

  function automatic int pend(int k, int r);
    if (r == 0 || ready[k][r] <= tact[k]) return 0;
    return ready[k][r] - tact[k];
  endfunction

  function automatic bit exp_stall(int k);
    bit haz;
    int lim;
    if (!rst_n) return 0;
    lim = (k == 0 && iss_store) ? 2 : 1;
    haz = iss_valid && ((iss_rs_used && pend(k, int'(iss_rs)) > 1) ||
                        (iss_rt_used && pend(k, int'(iss_rt)) > lim));
    return (mst[k] != 0) || mem_busy || (haz && !flush);
  endfunction

  function automatic bit exp_fire(int k);
    return rst_n && mst[k] == 0 && iss_valid && !exp_stall(k) && !flush;
  endfunction

  function automatic logic [15:0] exp_busy(int k);
    logic [15:0] m;
    m = '0;
    for (int r = 0; r < 16; r++) m[r] = (pend(k, r) != 0);
    return m;
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      tact[k] = 0; mst[k] = 0; msc[k] = 0;
      for (int r = 0; r < 16; r++) ready[k][r] = 0;
    end
  endtask

  task automatic mupdate(input int k, input bit st, input bit fi);
    bit idle;
    int lat;
    idle = (exp_busy(k) == 16'h0);
    if (mst[k] == 0 && st && msc[k] < 65535) msc[k]++;
    if (mst[k] == 0 && fi && hlt_req) mst[k] = 1;
    else if (mst[k] == 1 && idle && !mem_busy) mst[k] = 2;
    if (!mem_busy) tact[k]++;
    lat = (iss_lat == 0) ? 1 : int'(iss_lat);
    if (fi && iss_wr && iss_rd != 0 && !hlt_req) ready[k][iss_rd] = tact[k] + lat;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("reg_busy_map_fwd",   {16'h0, busy_a}, {16'h0, exp_busy(0)});
    chk("reg_busy_map_nofwd", {16'h0, busy_b}, {16'h0, exp_busy(1)});
    chk("hlt_fwd",            {31'h0, hlt_a},  {31'h0, mst[0] == 2});
    chk("hlt_nofwd",          {31'h0, hlt_b},  {31'h0, mst[1] == 2});
    chk("stall_cnt_fwd",      {16'h0, scnt_a}, msc[0]);
    chk("stall_cnt_nofwd",    {16'h0, scnt_b}, msc[1]);
  endtask

  // Called at posedge+1: drive inputs, check mid-cycle, advance one clock.
  task automatic step(input logic v, input logic [3:0] rs, input logic rsu, input logic [3:0] rt,
                      input logic rtu, input logic st, input logic wr, input logic [3:0] rd,
                      input logic [2:0] lat, input logic hr, input logic fl, input logic mb);
    bit es [2];
    bit ef [2];
    iss_valid = v; iss_rs = rs; iss_rs_used = rsu; iss_rt = rt; iss_rt_used = rtu;
    iss_store = st; iss_wr = wr; iss_rd = rd; iss_lat = lat; hlt_req = hr; flush = fl; mem_busy = mb;
    if (!rst_n) mreset();
    #4;
    for (int k = 0; k < 2; k++) begin
      es[k] = exp_stall(k);
      ef[k] = exp_fire(k);
    end
    chk("stall_fwd",    {31'h0, stall_a}, {31'h0, es[0]});
    chk("stall_nofwd",  {31'h0, stall_b}, {31'h0, es[1]});
    chk("fire_fwd",     {31'h0, fire_a},  {31'h0, ef[0]});
    chk("fire_nofwd",   {31'h0, fire_b},  {31'h0, ef[1]});
    check_all();
    @(posedge clk);
    if (rst_n) for (int k = 0; k < 2; k++) mupdate(k, es[k], ef[k]);
    #1;
  endtask

  task automatic idle_step(input logic mb);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mb);
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(1, 3, 1, 4, 1, 0, 1, 5, 2, 1, 0, 1);
    step(1, 3, 1, 4, 1, 0, 1, 5, 2, 0, 0, 0);
    rst_n = 1;
    mreset();
  endtask

  initial begin
    rst_n = 0;
    iss_valid = 0; iss_rs = 0; iss_rs_used = 0; iss_rt = 0; iss_rt_used = 0; iss_store = 0;
    iss_wr = 0; iss_rd = 0; iss_lat = 0; hlt_req = 0; flush = 0; mem_busy = 0;
    @(posedge clk);
    #1;
    do_reset();

    // ALU r3 then consumer of r3: no stall
    step(1, 1, 1, 2, 1, 0, 1, 3, 1, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0, 1, 4, 1, 0, 0, 0);
    chk("alu_alu_scnt", {16'h0, scnt_a}, 32'd0);

    // LW r5 then ADD rt=5: exactly one stall cycle
    step(1, 0, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0);
    chk("lw_busy5_after_issue", {31'h0, busy_a[5]}, 32'd1);
    step(1, 1, 1, 5, 1, 0, 1, 6, 1, 0, 0, 0);
    chk("lw_busy5_one_later", {31'h0, busy_a[5]}, 32'd1);
    step(1, 1, 1, 5, 1, 0, 1, 6, 1, 0, 0, 0);
    chk("lw_busy5_two_later", {31'h0, busy_a[5]}, 32'd0);
    chk("lw_use_scnt", {16'h0, scnt_a}, 32'd1);

    // LW r5 then SW rt=5: no stall with store forwarding, one without
    step(1, 0, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0);
    step(1, 2, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("lw_sw_scnt_fwd", {16'h0, scnt_a}, 32'd1);
    chk("lw_sw_scnt_nofwd", {16'h0, scnt_b}, 32'd2);
    step(1, 2, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0);

    // LW r7, then ADD rs=7 waiting through 3 busy cycles plus 1 hazard cycle
    step(1, 0, 0, 0, 0, 0, 1, 7, 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 7, 1, 0, 0, 0, 1, 8, 1, 0, 0, 1);
    chk("busy_frozen_busy7", {31'h0, busy_a[7]}, 32'd1);
    step(1, 7, 1, 0, 0, 0, 1, 8, 1, 0, 0, 0);
    step(1, 7, 1, 0, 0, 0, 1, 8, 1, 0, 0, 0);
    chk("busy_stall_scnt", {16'h0, scnt_a}, 32'd5);

    // Writer of r0 never becomes pending; reader of r0 never stalls
    idle_step(0);
    idle_step(0);
    step(1, 1, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0);
    chk("r0_busy_map", {16'h0, busy_a}, 32'd0);
    step(1, 0, 1, 0, 1, 0, 1, 9, 1, 0, 0, 0);

    // Flush with HLT in RUN must not halt
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    idle_step(0);
    chk("flush_hlt_no_halt", {31'h0, hlt_a}, 32'd0);

    // Randomized traffic checked against the model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom), 4'($urandom_range(0, 15)),
           1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
    end

    // LW r2 then HLT: drain until r2 ready, then halt; async reset clears halt
    do_reset();
    step(1, 0, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("drain_not_halted", {31'h0, hlt_a}, 32'd0);
    for (int i = 0; i < 4; i++) step(1, 2, 1, 0, 0, 0, 1, 3, 1, 0, 1, 0);
    chk("halted", {31'h0, hlt_a}, 32'd1);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_hlt", {31'h0, hlt_a}, 32'd0);
    chk("async_rst_stall", {31'h0, stall_a}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    mreset();

    // Reset mid-drain drops pending entries at once
    step(1, 0, 0, 0, 0, 0, 1, 2, 5, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle_step(0);
    chk("mid_drain_pending", {31'h0, busy_a[2]}, 32'd1);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_busy_map", {16'h0, busy_a}, 32'd0);
    chk("async_rst_busy_map_nofwd", {16'h0, busy_b}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    mreset();
    idle_step(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
